// File: rtl/pipeline_stall_ctrl.sv
// rtl/pipeline_stall_ctrl.sv - stall/flush controller for the 5-stage pipeline
//
// Purpose: resolves the hazards that EX-stage forwarding cannot handle.
//   load-use           -> one bubble into ID/EX, IF and ID held
//   taken branch/jump  -> IF/ID and ID/EX flushed, PC redirected
//   I/D memory wait    -> whole pipeline frozen
//   halt in MEM/WB     -> pipeline frozen until reset
//
// Ports:
//   CLK, nRST                  clock, asynchronous active-low reset
//   ihit, dhit                 instruction / data cache completion strobes
//   dREN_out_3, dWEN_out_3     EX/MEM holds a load / store
//   MemRead_out_2, wsel_out_2  ID/EX load flag and destination register
//   rs_out_1, rt_out_1         IF/ID source registers
//   pcsrc_taken                EX resolved a taken branch/jump
//   halt_out_4                 MEM/WB holds a halt
//   pc_en, *_en                PC and pipeline-register enables
//   ifid_flush, idex_flush     load a NOP on the enabled edge
//   dmem_req_en                gate for the dcache request
//   halt                       sticky halted indication
//   stall_cnt                  saturating count of non-advancing cycles plus bubbles

module pipeline_stall_ctrl #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             dREN_out_3,
    input  logic             dWEN_out_3,
    input  logic             MemRead_out_2,
    input  logic [REG_W-1:0] wsel_out_2,
    input  logic [REG_W-1:0] rs_out_1,
    input  logic [REG_W-1:0] rt_out_1,
    input  logic             pcsrc_taken,
    input  logic             halt_out_4,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             dmem_req_en,
    output logic             halt,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_dmem_done;
    logic             w_dmem_done_nxt;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_mreq;
    logic w_dready;
    logic w_advance;
    logic w_lu;
    logic w_bubble;
    logic w_cnt_inc;

    assign w_mreq    = dREN_out_3 | dWEN_out_3;
    // A data access already finished while waiting on ifetch counts as ready.
    assign w_dready  = !w_mreq | dhit | r_dmem_done;
    assign w_advance = (r_state == RUN) & ihit & w_dready;
    assign w_lu      = MemRead_out_2 & (wsel_out_2 != '0) &
                       ((wsel_out_2 == rs_out_1) | (wsel_out_2 == rt_out_1));
    // A taken branch squashes the dependent instruction, so no bubble is needed.
    assign w_bubble  = w_advance & !pcsrc_taken & w_lu;
    assign w_cnt_inc = (r_state == RUN) & (!w_advance | w_bubble);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state     <= RUN;
            r_dmem_done <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_dmem_done <= w_dmem_done_nxt;
            if (w_cnt_inc && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_dmem_done_nxt = r_dmem_done;
        pc_en           = 1'b0;
        ifid_en         = 1'b0;
        idex_en         = 1'b0;
        exmem_en        = 1'b0;
        memwb_en        = 1'b0;
        ifid_flush      = 1'b0;
        idex_flush      = 1'b0;
        dmem_req_en     = 1'b0;
        halt            = 1'b0;

        case (r_state)
            RUN: begin
                // Suppress reissue once the data is latched downstream.
                dmem_req_en = w_mreq & !r_dmem_done;
                if (w_advance) begin
                    exmem_en        = 1'b1;
                    memwb_en        = 1'b1;
                    idex_en         = 1'b1;
                    w_dmem_done_nxt = 1'b0;
                    if (pcsrc_taken) begin
                        pc_en      = 1'b1;
                        ifid_en    = 1'b1;
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (w_lu) begin
                        idex_flush = 1'b1;
                    end else begin
                        pc_en   = 1'b1;
                        ifid_en = 1'b1;
                    end
                end else if (w_mreq && dhit) begin
                    w_dmem_done_nxt = 1'b1;
                end
                if (halt_out_4) begin
                    w_state_nxt = HALTED;
                end
            end
            HALTED: begin
                halt = 1'b1;
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
    end

    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb/tb_pipeline_stall_ctrl.sv - table-driven bench for pipeline_stall_ctrl

module tb_pipeline_stall_ctrl;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ihit, dhit, dREN_out_3, dWEN_out_3, MemRead_out_2;
    logic [4:0]  wsel_out_2, rs_out_1, rt_out_1;
    logic        pcsrc_taken, halt_out_4;
    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_flush, idex_flush, dmem_req_en, halt;
    logic [15:0] stall_cnt;
    logic        s_pc_en, s_ifid_en, s_idex_en, s_exmem_en, s_memwb_en;
    logic        s_ifid_flush, s_idex_flush, s_dmem_req_en, s_halt;
    logic [3:0]  s_stall_cnt;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    pipeline_stall_ctrl #(.REG_W(5), .CNT_W(16)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .dREN_out_3(dREN_out_3), .dWEN_out_3(dWEN_out_3),
        .MemRead_out_2(MemRead_out_2), .wsel_out_2(wsel_out_2),
        .rs_out_1(rs_out_1), .rt_out_1(rt_out_1),
        .pcsrc_taken(pcsrc_taken), .halt_out_4(halt_out_4),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .dmem_req_en(dmem_req_en), .halt(halt), .stall_cnt(stall_cnt)
    );

    pipeline_stall_ctrl #(.REG_W(5), .CNT_W(4)) dut_small (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .dREN_out_3(dREN_out_3), .dWEN_out_3(dWEN_out_3),
        .MemRead_out_2(MemRead_out_2), .wsel_out_2(wsel_out_2),
        .rs_out_1(rs_out_1), .rt_out_1(rt_out_1),
        .pcsrc_taken(pcsrc_taken), .halt_out_4(halt_out_4),
        .pc_en(s_pc_en), .ifid_en(s_ifid_en), .idex_en(s_idex_en),
        .exmem_en(s_exmem_en), .memwb_en(s_memwb_en),
        .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush),
        .dmem_req_en(s_dmem_req_en), .halt(s_halt), .stall_cnt(s_stall_cnt)
    );

    // Input order: ihit dhit dren dwen memread wsel rs rt pcsrc halt4
    // Output order: pc ifid idex exmem memwb ifid_fl idex_fl dreq halt
    typedef struct {
        string       name;
        logic [4:0]  ctl;      // ihit dhit dren dwen memread
        logic [4:0]  wsel;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        pcsrc;
        logic        halt4;
        logic [8:0]  exp_out;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs[18];

    function automatic logic [8:0] outs();
        return {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                ifid_flush, idex_flush, dmem_req_en, halt};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] ctl, input logic [4:0] ws, input logic [4:0] rs,
                         input logic [4:0] rt, input logic pc, input logic h4);
        {ihit, dhit, dREN_out_3, dWEN_out_3, MemRead_out_2} = ctl;
        wsel_out_2  = ws;
        rs_out_1    = rs;
        rt_out_1    = rt;
        pcsrc_taken = pc;
        halt_out_4  = h4;
    endtask

    initial begin
        //          name            ctl       wsel rs  rt  pc h4  outputs        cnt
        vecs[0]  = '{"idle0",      5'b00000, 0,  0,  0,  0, 0, 9'b000000000, 0};
        vecs[1]  = '{"idle1",      5'b00000, 0,  0,  0,  0, 0, 9'b000000000, 1};
        vecs[2]  = '{"idle2",      5'b00000, 0,  0,  0,  0, 0, 9'b000000000, 2};
        vecs[3]  = '{"run",        5'b10000, 0,  0,  0,  0, 0, 9'b111110000, 3};
        vecs[4]  = '{"lu_rs",      5'b10001, 8,  8,  0,  0, 0, 9'b001110100, 3};
        vecs[5]  = '{"after_lu",   5'b10000, 0,  0,  0,  0, 0, 9'b111110000, 4};
        vecs[6]  = '{"lu_rt",      5'b10001, 5,  3,  5,  0, 0, 9'b001110100, 4};
        vecs[7]  = '{"lu_r0",      5'b10001, 0,  0,  0,  0, 0, 9'b111110000, 5};
        vecs[8]  = '{"br_over_lu", 5'b10001, 8,  8,  0,  1, 0, 9'b111111100, 5};
        vecs[9]  = '{"dhit_noi",   5'b01100, 0,  0,  0,  0, 0, 9'b000000010, 5};
        vecs[10] = '{"done_wait",  5'b00100, 0,  0,  0,  0, 0, 9'b000000000, 6};
        vecs[11] = '{"done_adv",   5'b10100, 0,  0,  0,  0, 0, 9'b111110000, 7};
        vecs[12] = '{"load_wait",  5'b10100, 0,  0,  0,  0, 0, 9'b000000010, 7};
        vecs[13] = '{"store_hit",  5'b11010, 0,  0,  0,  0, 0, 9'b111110010, 8};
        vecs[14] = '{"store_lu",   5'b10011, 8,  8,  0,  0, 0, 9'b000000010, 8};
        vecs[15] = '{"halt_in",    5'b10000, 0,  0,  0,  0, 1, 9'b111110000, 9};
        vecs[16] = '{"halted",     5'b10000, 0,  0,  0,  0, 0, 9'b000000001, 9};
        vecs[17] = '{"halted_ign", 5'b01100, 0,  0,  0,  1, 1, 9'b000000001, 9};

        nRST = 1'b0;
        drive(5'b00000, 0, 0, 0, 0, 0);
        #12;
        check("reset_outs", {23'd0, outs()}, 32'd0);
        check("reset_cnt", {16'd0, stall_cnt}, 32'd0);
        @(posedge CLK);
        #1 nRST = 1'b1;

        for (int i = 0; i < 18; i++) begin
            @(negedge CLK);
            drive(vecs[i].ctl, vecs[i].wsel, vecs[i].rs, vecs[i].rt, vecs[i].pcsrc, vecs[i].halt4);
            #1;
            check({vecs[i].name, "_out"}, {23'd0, outs()}, {23'd0, vecs[i].exp_out});
            check({vecs[i].name, "_cnt"}, {16'd0, stall_cnt}, {16'd0, vecs[i].exp_cnt});
        end

        // Asynchronous reset while halted returns everything at once.
        @(negedge CLK);
        nRST = 1'b0;
        #1;
        check("rst_halt_flag", {31'd0, halt}, 32'd0);
        check("rst_halt_cnt", {16'd0, stall_cnt}, 32'd0);

        // dmem_done is set while waiting on ifetch, then dropped by reset.
        drive(5'b01100, 0, 0, 0, 0, 0);
        #1 nRST = 1'b1;
        @(negedge CLK);
        dhit = 1'b0;
        #1;
        check("done_held_req", {31'd0, dmem_req_en}, 32'd0);
        nRST = 1'b0;
        #1;
        check("done_dropped_req", {31'd0, dmem_req_en}, 32'd1);
        check("done_dropped_cnt", {16'd0, stall_cnt}, 32'd0);

        // Saturation of the narrow counter with ihit held low.
        drive(5'b00000, 0, 0, 0, 0, 0);
        #1 nRST = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge CLK);
            if (k >= 14) begin
                check($sformatf("sat4_k%0d", k), {28'd0, s_stall_cnt}, (k < 15) ? k : 15);
            end
        end
        check("cnt16_no_sat", {16'd0, stall_cnt}, 32'd20);
        check("sat_en_off", {23'd0, outs()}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
